// File: rtl/ram_host_sequencer_if.sv
// Host command/response bundle for ram_host_sequencer.
// The master issues commands and the slave returns READ data.
interface ram_host_sequencer_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ram_host_sequencer.sv
// Arbitrates the program/data RAM between host WRITE/READ commands (CPU halted)
// and a budgeted CPU run, where the CPU's RAM signals pass straight through.
module ram_host_sequencer #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  ram_host_sequencer_if.slave host,
  output logic          run_done,
  output logic          running,
  output logic          cpu_rst,
  input  logic          cpu_wrEn,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  typedef enum logic [2:0] {
    S_HALT = 3'd0,
    S_WR   = 3'd1,
    S_RD_A = 3'd2,
    S_RD_W = 3'd3,
    S_RUN  = 3'd4
  } state_t;

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          we_q;
  logic [CW-1:0] budget;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_data_q;
  logic          cmd_ready_c;
  logic          cmd_fire;
  logic          run_sel;
  logic          expire;

  // Only HALT may interrupt a run; the short RAM sequences are never interruptible.
  always_comb begin
    cmd_ready_c = 1'b0;
    unique case (state)
      S_HALT:  cmd_ready_c = 1'b1;
      S_RUN:   cmd_ready_c = (host.cmd_op == OP_HALT);
      default: cmd_ready_c = 1'b0;
    endcase
    cmd_ready_c = cmd_ready_c & ~rst;
  end

  assign host.cmd_ready = cmd_ready_c;
  assign cmd_fire       = host.cmd_valid & cmd_ready_c;
  assign run_sel        = (state == S_RUN);
  assign expire         = (budget == CW'(1));

  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;

  // RAM mux; rst masks the write strobe so a reset landing in WR or RUN never stores.
  assign ram_we    = ~rst & (run_sel ? cpu_wrEn : we_q);
  assign ram_addr  = run_sel ? cpu_addr  : addr_q;
  assign ram_din   = run_sel ? cpu_wdata : data_q;
  assign cpu_rdata = ram_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HALT;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      budget      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      run_done    <= 1'b0;
      running     <= 1'b0;
      cpu_rst     <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      run_done    <= 1'b0;
      we_q        <= 1'b0;
      unique case (state)
        S_HALT: begin
          if (cmd_fire) begin
            unique case (host.cmd_op)
              OP_WRITE: begin
                addr_q <= host.cmd_addr;
                data_q <= host.cmd_data;
                we_q   <= 1'b1;
                state  <= S_WR;
              end
              OP_READ: begin
                addr_q <= host.cmd_addr;
                state  <= S_RD_A;
              end
              OP_RUN: begin
                budget  <= CW'(host.cmd_data);
                cpu_rst <= 1'b0;
                running <= 1'b1;
                state   <= S_RUN;
              end
              default: state <= S_HALT;
            endcase
          end
        end
        S_WR:   state <= S_HALT;
        S_RD_A: state <= S_RD_W;
        S_RD_W: begin
          rsp_data_q  <= ram_dout;
          rsp_valid_q <= 1'b1;
          state       <= S_HALT;
        end
        S_RUN: begin
          // Budget 0 means unlimited; expiry owns run_done even if HALT arrives together.
          if (expire || cmd_fire) begin
            cpu_rst  <= 1'b1;
            running  <= 1'b0;
            run_done <= expire;
            budget   <= '0;
            state    <= S_HALT;
          end else if (budget != '0) begin
            budget <= budget - CW'(1);
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_host_sequencer.sv
// Directed bench for ram_host_sequencer with a registered-read RAM model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_ram_host_sequencer;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_host_sequencer_if #(.AW(AW), .DW(DW)) host ();

  logic          run_done, running, cpu_rst;
  logic          cpu_wrEn;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  logic [DW-1:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  ram_host_sequencer #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (host),
    .run_done  (run_done),
    .running   (running),
    .cpu_rst   (cpu_rst),
    .cpu_wrEn  (cpu_wrEn),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    @(negedge clk);
    host.cmd_valid = 1'b1; host.cmd_op = 2'b00; host.cmd_addr = a; host.cmd_data = d;
    #1;
    checks++;
    if (host.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s_wr_accept cmd_ready=%b want 1", tag, host.cmd_ready);
    end
    @(negedge clk);
    host.cmd_valid = 1'b0;
    #1;
    checks++;
    if ({ram_we, ram_addr, ram_din, host.cmd_ready} !== {1'b1, a, d, 1'b0}) begin
      errors++;
      $display("FAIL %s_wr_strobe we=%b addr=%h din=%h rdy=%b want we=1 addr=%h din=%h rdy=0",
               tag, ram_we, ram_addr, ram_din, host.cmd_ready, a, d);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({ram_we, host.cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL %s_wr_done we=%b rdy=%b want we=0 rdy=1", tag, ram_we, host.cmd_ready);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    @(negedge clk);
    host.cmd_valid = 1'b1; host.cmd_op = 2'b01; host.cmd_addr = a;
    #1;
    checks++;
    if (host.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s_rd_accept cmd_ready=%b want 1", tag, host.cmd_ready);
    end
    @(negedge clk);
    host.cmd_valid = 1'b0;
    #1;
    checks++;
    if ({host.cmd_ready, ram_we, ram_addr, host.rsp_valid} !== {1'b0, 1'b0, a, 1'b0}) begin
      errors++;
      $display("FAIL %s_rd_addr rdy=%b we=%b addr=%h rsp_v=%b want rdy=0 we=0 addr=%h rsp_v=0",
               tag, host.cmd_ready, ram_we, ram_addr, host.rsp_valid, a);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({host.cmd_ready, host.rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL %s_rd_wait rdy=%b rsp_v=%b want 0 0", tag, host.cmd_ready, host.rsp_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({host.rsp_valid, host.rsp_data, host.cmd_ready} !== {1'b1, exp, 1'b1}) begin
      errors++;
      $display("FAIL %s_rd_rsp rsp_v=%b data=%h rdy=%b want rsp_v=1 data=%h rdy=1",
               tag, host.rsp_valid, host.rsp_data, host.cmd_ready, exp);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({host.rsp_valid, host.rsp_data} !== {1'b0, exp}) begin
      errors++;
      $display("FAIL %s_rd_hold rsp_v=%b data=%h want rsp_v=0 data=%h", tag, host.rsp_valid, host.rsp_data, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({cpu_rst, running, run_done, host.rsp_valid, host.rsp_data, ram_we, host.cmd_ready}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state cpu_rst=%b run=%b done=%b rsp_v=%b rsp=%h we=%b rdy=%b want 1 0 0 0 0000 0 1",
               cpu_rst, running, run_done, host.rsp_valid, host.rsp_data, ram_we, host.cmd_ready);
    end
  endtask

  task automatic test_halt_noop();
    @(negedge clk);
    host.cmd_valid = 1'b1; host.cmd_op = 2'b11;
    #1;
    checks++;
    if (host.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL halt_noop_accept rdy=%b want 1", host.cmd_ready);
    end
    @(negedge clk);
    host.cmd_valid = 1'b0;
    #1;
    checks++;
    if ({host.cmd_ready, running, cpu_rst, run_done} !== 4'b1010) begin
      errors++; $display("FAIL halt_noop_state rdy/run/cpu_rst/done=%b want 1010",
                         {host.cmd_ready, running, cpu_rst, run_done});
    end
  endtask

  task automatic test_write_read();
    do_write(8'h05, 16'hBEEF, "wr05");
    do_read(8'h05, 16'hBEEF, "rd05");
  endtask

  task automatic test_run_budget();
    for (int i = 0; i < 4; i++) do_write(8'(i), 16'(16'h1000 + i), "prog");
    @(negedge clk);
    host.cmd_valid = 1'b1; host.cmd_op = 2'b10; host.cmd_data = 16'd10;
    #1;
    checks++;
    if (host.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL run10_accept rdy=%b want 1", host.cmd_ready);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      host.cmd_valid = 1'b0; host.cmd_op = 2'b00;
      #1;
      checks++;
      if ({cpu_rst, running, run_done, host.cmd_ready} !== 4'b0100) begin
        errors++; $display("FAIL run10_cycle%0d cpu_rst/run/done/rdy=%b want 0100", i,
                           {cpu_rst, running, run_done, host.cmd_ready});
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({cpu_rst, running, run_done, host.cmd_ready} !== 4'b1011) begin
      errors++; $display("FAIL run10_expire cpu_rst/run/done/rdy=%b want 1011",
                         {cpu_rst, running, run_done, host.cmd_ready});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({run_done, running, cpu_rst} !== 3'b001) begin
      errors++; $display("FAIL run10_after done/run/cpu_rst=%b want 001", {run_done, running, cpu_rst});
    end
  endtask

  task automatic test_unlimited();
    @(negedge clk);
    host.cmd_valid = 1'b1; host.cmd_op = 2'b10; host.cmd_data = 16'd0;
    #1;
    checks++;
    if (host.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL run0_accept rdy=%b want 1", host.cmd_ready);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      host.cmd_valid = 1'b1; host.cmd_op = 2'b00; host.cmd_addr = 8'h30; host.cmd_data = 16'hAAAA;
      cpu_wrEn = (i == 5); cpu_addr = 8'(8'h40 + i); cpu_wdata = 16'(i);
      #1;
      checks++;
      if ({host.cmd_ready, running, ram_we, ram_addr, ram_din}
          !== {1'b0, 1'b1, (i == 5), 8'(8'h40 + i), 16'(i)}) begin
        errors++;
        $display("FAIL run0_hold%0d rdy=%b run=%b we=%b addr=%h din=%h want rdy=0 run=1 we=%b addr=%h din=%h",
                 i, host.cmd_ready, running, ram_we, ram_addr, ram_din, (i == 5), 8'(8'h40 + i), 16'(i));
      end
    end
    @(negedge clk);
    cpu_wrEn = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host.cmd_op = 2'b11;
    #1;
    checks++;
    if (host.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL run0_halt_accept rdy=%b want 1", host.cmd_ready);
    end
    @(negedge clk);
    host.cmd_op = 2'b00;
    #1;
    checks++;
    if ({cpu_rst, running, run_done, host.cmd_ready} !== 4'b1001) begin
      errors++; $display("FAIL run0_halted cpu_rst/run/done/rdy=%b want 1001",
                         {cpu_rst, running, run_done, host.cmd_ready});
    end
    @(negedge clk);
    host.cmd_valid = 1'b0;
    #1;
    checks++;
    if ({ram_we, ram_addr, ram_din} !== {1'b1, 8'h30, 16'hAAAA}) begin
      errors++; $display("FAIL pending_write we=%b addr=%h din=%h want 1 30 aaaa", ram_we, ram_addr, ram_din);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++; $display("FAIL pending_write_end we=%b want 0", ram_we);
    end
    do_read(8'h30, 16'hAAAA, "rd30");
    do_read(8'h45, 16'h0005, "rd45");
  endtask

  task automatic test_cpu_store();
    @(negedge clk);
    host.cmd_valid = 1'b1; host.cmd_op = 2'b10; host.cmd_data = 16'd0;
    #1;
    checks++;
    if (host.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL store_run_accept rdy=%b want 1", host.cmd_ready);
    end
    @(negedge clk);
    host.cmd_valid = 1'b0;
    cpu_wrEn = 1'b1; cpu_addr = 8'h20; cpu_wdata = 16'h1234;
    #1;
    checks++;
    if ({ram_we, ram_addr, ram_din} !== {1'b1, 8'h20, 16'h1234}) begin
      errors++; $display("FAIL cpu_store we=%b addr=%h din=%h want 1 20 1234", ram_we, ram_addr, ram_din);
    end
    @(negedge clk);
    cpu_wrEn = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host.cmd_valid = 1'b1; host.cmd_op = 2'b11;
    #1;
    checks++;
    if ({host.cmd_ready, ram_we} !== 2'b10) begin
      errors++; $display("FAIL store_halt rdy=%b we=%b want 1 0", host.cmd_ready, ram_we);
    end
    @(negedge clk);
    host.cmd_valid = 1'b0;
    #1;
    checks++;
    if ({cpu_rst, run_done} !== 2'b10) begin
      errors++; $display("FAIL store_halted cpu_rst=%b done=%b want 1 0", cpu_rst, run_done);
    end
    do_read(8'h20, 16'h1234, "rd20");
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    host.cmd_valid = 1'b1; host.cmd_op = 2'b01; host.cmd_addr = 8'h05;
    #1;
    checks++;
    if (host.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rstrd_accept rdy=%b want 1", host.cmd_ready);
    end
    @(negedge clk);
    host.cmd_valid = 1'b0; rst = 1'b1;
    #1;
    checks++;
    if ({ram_we, host.rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL rstrd_cycle we=%b rsp_v=%b want 0 0", ram_we, host.rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({cpu_rst, host.cmd_ready, host.rsp_valid, host.rsp_data, running} !== {1'b1, 1'b1, 1'b0, 16'h0000, 1'b0}) begin
      errors++; $display("FAIL rstrd_after cpu_rst=%b rdy=%b rsp_v=%b rsp=%h run=%b want 1 1 0 0000 0",
                         cpu_rst, host.cmd_ready, host.rsp_valid, host.rsp_data, running);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (host.rsp_valid !== 1'b0) begin
        errors++; $display("FAIL rstrd_no_rsp%0d rsp_v=%b want 0", i, host.rsp_valid);
      end
    end
    @(negedge clk);
    host.cmd_valid = 1'b1; host.cmd_op = 2'b00; host.cmd_addr = 8'h06; host.cmd_data = 16'h5555;
    #1;
    checks++;
    if (host.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rstwr_accept rdy=%b want 1", host.cmd_ready);
    end
    @(negedge clk);
    host.cmd_valid = 1'b0; rst = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++; $display("FAIL rstwr_cycle we=%b want 0", ram_we);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({ram_we, host.cmd_ready, cpu_rst} !== 3'b011) begin
      errors++; $display("FAIL rstwr_after we=%b rdy=%b cpu_rst=%b want 0 1 1", ram_we, host.cmd_ready, cpu_rst);
    end
    do_read(8'h06, 16'h0000, "rd06");
  endtask

  task automatic test_halt_on_expiry();
    @(negedge clk);
    host.cmd_valid = 1'b1; host.cmd_op = 2'b10; host.cmd_data = 16'd3;
    #1;
    checks++;
    if (host.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL run3_accept rdy=%b want 1", host.cmd_ready);
    end
    @(negedge clk);
    host.cmd_valid = 1'b0; host.cmd_op = 2'b00;
    @(negedge clk);
    @(negedge clk);
    host.cmd_valid = 1'b1; host.cmd_op = 2'b11;
    #1;
    checks++;
    if ({host.cmd_ready, running, cpu_rst} !== 3'b110) begin
      errors++; $display("FAIL run3_last rdy/run/cpu_rst=%b want 110", {host.cmd_ready, running, cpu_rst});
    end
    @(negedge clk);
    host.cmd_valid = 1'b0; host.cmd_op = 2'b00;
    #1;
    checks++;
    if ({running, run_done, cpu_rst, host.cmd_ready} !== 4'b0111) begin
      errors++; $display("FAIL run3_exit run/done/cpu_rst/rdy=%b want 0111",
                         {running, run_done, cpu_rst, host.cmd_ready});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({running, run_done, cpu_rst} !== 3'b001) begin
        errors++; $display("FAIL run3_post%0d run/done/cpu_rst=%b want 001", i, {running, run_done, cpu_rst});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    host.cmd_valid = 1'b0; host.cmd_op = 2'b00; host.cmd_addr = '0; host.cmd_data = '0;
    cpu_wrEn = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    test_reset();
    test_halt_noop();
    test_write_read();
    test_run_budget();
    test_unlimited();
    test_cpu_store();
    test_reset_mid_op();
    test_halt_on_expiry();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_host_sequencer.md
Name: ram_host_sequencer

Overview:
Sequencer between an external host command port, the 16-bit single-port program/data RAM and the TinyMIPS-class CPU. While the CPU is halted (held in reset), it owns the RAM port and services host WRITE/READ commands. On RUN it releases the CPU for a bounded or unbounded cycle budget, muxing the CPU's RAM signals straight through. It re-takes the RAM on HALT or when the budget expires.

Parameters:
AW, 8, RAM address width
DW, 16, RAM/command data width
CW, 16, run-budget counter width (budget taken from cmd_data[CW-1:0])

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  host command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  00 WRITE, 01 READ, 10 RUN, 11 HALT
cmd_addr  in  AW  RAM address for WRITE/READ
cmd_data  in  DW  write data (WRITE) / cycle budget (RUN)
rsp_valid  out  1  one-cycle pulse, READ data valid
rsp_data  out  DW  READ result, held until next READ
run_done  out  1  one-cycle pulse when budget expires
running  out  1  high in RUN state
cpu_rst  out  1  reset to CPU
cpu_wrEn  in  1  CPU write enable
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  RAM read data to CPU (= ram_dout, always)
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_din  out  DW  RAM write data
ram_dout  in  DW  RAM read data; registered, valid the cycle after the address is sampled

Behaviour:
- States: HALT, WR, RD_A, RD_W, RUN. Registered state; all transitions on posedge clk.
- Reset (any state, any cycle): state=HALT, cpu_rst=1, running=0, rsp_valid=0, run_done=0, rsp_data=0, budget=0, internal ram_we reg=0. An in-flight READ is discarded; no RAM write occurs in the reset cycle or the following cycle.
- cmd_ready (combinational):
  - HALT: 1 for all ops.
  - RUN: 1 only when cmd_op==HALT.
  - WR, RD_A, RD_W: 0.
- HALT state: cpu_rst=1. Controller drives the RAM from internal registers: ram_we=0 unless in WR.
  - WRITE accepted at cycle T: latch addr/data → WR at T+1. In WR: ram_we=1, ram_addr=latched addr, ram_din=latched data for exactly one cycle → HALT at T+2.
  - READ accepted at T:
    - T+1, RD_A: ram_addr=addr, ram_we=0.
    - T+2, RD_W: ram_dout valid; captured into rsp_data.
    - T+3: rsp_valid=1 for one cycle, state=HALT, cmd_ready=1 again.
    - No backpressure on rsp.
  - RUN accepted at T: budget<=cmd_data[CW-1:0] → RUN at T+1.
  - HALT accepted in HALT: no-op, stays HALT.
- RUN state: cpu_rst=0, running=1. RAM mux is combinational pass-through: ram_we=cpu_wrEn, ram_addr=cpu_addr, ram_din=cpu_wdata.
  - Budget B>0: RUN lasts exactly B cycles. The counter decrements each RUN cycle; when it reaches 1 in RUN, next state=HALT and run_done pulses in the first HALT cycle.
  - Budget 0: unlimited; only a HALT command exits.
  - HALT accepted at T in RUN: HALT at T+1, cpu_rst=1 from T+1, no run_done.
  - A HALT accepted in the same cycle the budget expires: exit once, run_done=1 (expiry wins for the pulse).
  - A CPU store issued in the last RUN cycle completes (mux still selects the CPU in that cycle).
- cpu_rdata=ram_dout in all states; the CPU ignores it while in reset.
- Addresses are AW bits and carry no wrap logic; all address/data widths are passed unchanged.
- No combinational path from cmd_* to ram_* (commands take effect one cycle after acceptance).

Test Plan:
- rst 2 cycles, then WRITE addr 0x05 data 0xBEEF; READ 0x05 (accepted T) → ram_we=1 one cycle at write+1; rsp_valid=1 only at T+3 with rsp_data=0xBEEF; cmd_ready=0 T+1..T+2.
- WRITE program words to 0x00..0x03, RUN data 10 → cpu_rst low exactly 10 cycles, running high same 10 cycles, run_done single pulse next cycle, cmd_ready=1 after.
- RUN data 0, then WRITE held valid for 20 cycles → cmd_ready=0 throughout, ram_we follows only cpu_wrEn; then HALT → accepted, cpu_rst=1 next cycle, pending WRITE then accepted.
- In RUN force cpu_wrEn=1, cpu_addr=0x20, cpu_wdata=0x1234 for one cycle → ram_we=1/addr 0x20/din 0x1234 same cycle; HALT, READ 0x20 → rsp_data=0x1234.
- READ accepted, assert rst in RD_A cycle → no rsp_valid ever, state HALT, cpu_rst=1, cmd_ready=1 after reset; repeat with rst in WR → ram_we low that cycle.
- RUN data 3 with HALT presented on third RUN cycle → exactly one exit, run_done=1 once, running low afterwards.
